control_unit: RTL and testbench

- Sequencing controller that sits directly upstream of the register-file/ALU datapath.
- Holds the program counter (PC) and instruction register (IR), and fetches 16-bit instructions from an asynchronous-read instruction memory.
- Decodes each instruction and drives every datapath control: RF read/write addresses, RF write enable, ALU select, data-memory address/write and RF write-source mux.
- Executes NOOP, STORE, LOAD, ADD, SUB and HALT.

---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/pc_ir_reg.sv | 45 ++++
 rtl/control_unit.sv | 168 ++++++++++++++++
 tb/tb_control_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_pkg
// Brief   : Shared types and constants for the control unit: FSM state
//           encoding, opcodes, ALU selects and instruction field positions.
// Revision: 1.0 - initial release
// ============================================================================
package ctrl_pkg;

   // 4-bit FSM encoding, also exported on the State debug port
   typedef enum logic [3:0] {
      ST_INIT   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_NOOP   = 4'd3,
      ST_LOAD_A = 4'd4,
      ST_LOAD_B = 4'd5,
      ST_STORE  = 4'd6,
      ST_ADD    = 4'd7,
      ST_SUB    = 4'd8,
      ST_HALT   = 4'd9
   } state_t;

   localparam logic [3:0] OP_NOOP  = 4'd0;
   localparam logic [3:0] OP_STORE = 4'd1;
   localparam logic [3:0] OP_LOAD  = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_HALT  = 4'd5;

   localparam logic [2:0] ALU_ZERO = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_INC  = 3'd7;

   // Instruction field positions
   localparam int OPC_MSB   = 15;
   localparam int OPC_LSB   = 12;
   localparam int RA_MSB    = 11;
   localparam int RA_LSB    = 8;
   localparam int RB_MSB    = 7;
   localparam int RB_LSB    = 4;
   localparam int RW_MSB    = 3;
   localparam int RW_LSB    = 0;
   localparam int ST_DA_MSB = 7;   // STORE data address
   localparam int ST_DA_LSB = 0;
   localparam int LD_DA_MSB = 11;  // LOAD data address
   localparam int LD_DA_LSB = 4;

   // Execute state for an opcode; unassigned opcodes behave as NOOP
   function automatic state_t opcode_to_state(input logic [3:0] op);
      case (op)
         OP_STORE: return ST_STORE;
         OP_LOAD:  return ST_LOAD_A;
         OP_ADD:   return ST_ADD;
         OP_SUB:   return ST_SUB;
         OP_HALT:  return ST_HALT;
         default:  return ST_NOOP;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_ir_reg.sv
`default_nettype none
// ============================================================================
// Module  : pc_ir_reg
// Brief   : Program counter (wrapping incrementer) and instruction register.
// Revision: 1.0 - initial release
// ============================================================================
module pc_ir_reg #(
   parameter int PC_W = 7
) (
   input  logic            Clk,
   input  logic            Reset_n,
   input  logic            ld,
   input  logic            up,
   input  logic [15:0]     IM_data,
   output logic [PC_W-1:0] PC,
   output logic [15:0]     IR
);

   logic [PC_W-1:0] pc_d, pc_q;
   logic [15:0]     ir_d, ir_q;

   // Next PC wraps naturally at 2^PC_W; IR captures the fetched word
   always_comb begin
      pc_d = pc_q;
      ir_d = ir_q;
      if (up) pc_d = pc_q + 1'b1;
      if (ld) ir_d = IM_data;
   end

   // PC/IR state, cleared asynchronously
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pc_q <= '0;
         ir_q <= '0;
      end else begin
         pc_q <= pc_d;
         ir_q <= ir_d;
      end
   end

   assign PC = pc_q;
   assign IR = ir_q;

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module  : control_unit
// Brief   : Fetch/decode/execute sequencer driving RF, ALU and data-memory
//           controls. Every control output is a flop, so nothing toggles
//           combinationally from IM_data.
// Revision: 1.0 - initial release
// ============================================================================
module control_unit
   import ctrl_pkg::*;
#(
   parameter int PC_W     = 7,
   parameter int D_ADDR_W = 8
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic [15:0]         IM_data,
   output logic [PC_W-1:0]     IM_Addr,
   output logic [15:0]         IR,
   output logic [D_ADDR_W-1:0] D_Addr,
   output logic                D_wr,
   output logic                RF_s,
   output logic                RF_W_en,
   output logic [3:0]          RF_W_Addr,
   output logic [3:0]          RF_Ra_Addr,
   output logic [3:0]          RF_Rb_Addr,
   output logic [2:0]          ALU_s0,
   output logic [3:0]          State
);

   state_t              state_d, state_q;
   logic                fetch_w;
   logic [PC_W-1:0]     pc_w;
   logic [15:0]         ir_w;
   logic [15:0]         ir_nx;

   logic [D_ADDR_W-1:0] d_addr_d, d_addr_q;
   logic                d_wr_d, d_wr_q;
   logic                rf_s_d, rf_s_q;
   logic                rf_w_en_d, rf_w_en_q;
   logic [3:0]          rf_w_addr_d, rf_w_addr_q;
   logic [3:0]          rf_ra_d, rf_ra_q;
   logic [3:0]          rf_rb_d, rf_rb_q;
   logic [2:0]          alu_s0_d, alu_s0_q;

   assign fetch_w = (state_q == ST_FETCH);

   pc_ir_reg #(.PC_W(PC_W)) u_pc_ir (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .ld      (fetch_w),
      .up      (fetch_w),
      .IM_data (IM_data),
      .PC      (pc_w),
      .IR      (ir_w)
   );

   // IR contents as they will be after this edge; outputs are registered
   // one cycle ahead, so DECODE lookahead needs the word being fetched now
   assign ir_nx = fetch_w ? IM_data : ir_w;

   // Next-state sequencing
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT:   state_d = ST_FETCH;
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: state_d = opcode_to_state(ir_w[OPC_MSB:OPC_LSB]);
         ST_LOAD_A: state_d = ST_LOAD_B;
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_FETCH;
      endcase
   end

   // Control values for the state being entered
   always_comb begin
      d_addr_d    = '0;
      d_wr_d      = 1'b0;
      rf_s_d      = 1'b0;
      rf_w_en_d   = 1'b0;
      rf_w_addr_d = '0;
      rf_ra_d     = '0;
      rf_rb_d     = '0;
      alu_s0_d    = ALU_ZERO;
      case (state_d)
         ST_DECODE: begin
            case (ir_nx[OPC_MSB:OPC_LSB])
               OP_STORE: begin
                  d_addr_d = D_ADDR_W'(ir_nx[ST_DA_MSB:ST_DA_LSB]);
                  rf_ra_d  = ir_nx[RA_MSB:RA_LSB];
               end
               OP_LOAD: begin
                  d_addr_d    = D_ADDR_W'(ir_nx[LD_DA_MSB:LD_DA_LSB]);
                  rf_w_addr_d = ir_nx[RW_MSB:RW_LSB];
               end
               OP_ADD, OP_SUB: begin
                  rf_ra_d     = ir_nx[RA_MSB:RA_LSB];
                  rf_rb_d     = ir_nx[RB_MSB:RB_LSB];
                  rf_w_addr_d = ir_nx[RW_MSB:RW_LSB];
               end
               default: ;
            endcase
         end
         ST_STORE: begin
            d_addr_d = D_ADDR_W'(ir_nx[ST_DA_MSB:ST_DA_LSB]);
            rf_ra_d  = ir_nx[RA_MSB:RA_LSB];
            d_wr_d   = 1'b1;
         end
         ST_LOAD_A: begin
            d_addr_d = D_ADDR_W'(ir_nx[LD_DA_MSB:LD_DA_LSB]);
            rf_s_d   = 1'b1;
         end
         ST_LOAD_B: begin
            d_addr_d    = D_ADDR_W'(ir_nx[LD_DA_MSB:LD_DA_LSB]);
            rf_s_d      = 1'b1;
            rf_w_addr_d = ir_nx[RW_MSB:RW_LSB];
            rf_w_en_d   = 1'b1;
         end
         ST_ADD, ST_SUB: begin
            rf_ra_d     = ir_nx[RA_MSB:RA_LSB];
            rf_rb_d     = ir_nx[RB_MSB:RB_LSB];
            rf_w_addr_d = ir_nx[RW_MSB:RW_LSB];
            rf_w_en_d   = 1'b1;
            alu_s0_d    = (state_d == ST_ADD) ? ALU_ADD : ALU_SUB;
         end
         default: ;
      endcase
   end

   // FSM state and registered outputs; async reset drops strobes at once
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= ST_INIT;
         d_addr_q    <= '0;
         d_wr_q      <= 1'b0;
         rf_s_q      <= 1'b0;
         rf_w_en_q   <= 1'b0;
         rf_w_addr_q <= '0;
         rf_ra_q     <= '0;
         rf_rb_q     <= '0;
         alu_s0_q    <= ALU_ZERO;
      end else begin
         state_q     <= state_d;
         d_addr_q    <= d_addr_d;
         d_wr_q      <= d_wr_d;
         rf_s_q      <= rf_s_d;
         rf_w_en_q   <= rf_w_en_d;
         rf_w_addr_q <= rf_w_addr_d;
         rf_ra_q     <= rf_ra_d;
         rf_rb_q     <= rf_rb_d;
         alu_s0_q    <= alu_s0_d;
      end
   end

   assign IM_Addr    = pc_w;
   assign IR         = ir_w;
   assign State      = state_q;
   assign D_Addr     = d_addr_q;
   assign D_wr       = d_wr_q;
   assign RF_s       = rf_s_q;
   assign RF_W_en    = rf_w_en_q;
   assign RF_W_Addr  = rf_w_addr_q;
   assign RF_Ra_Addr = rf_ra_q;
   assign RF_Rb_Addr = rf_rb_q;
   assign ALU_s0     = alu_s0_q;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_control_unit
// Brief   : Self-checking bench for control_unit. A per-instruction model
//           expands each instruction word into its expected cycle stream.
// Revision: 1.0 - initial release
// ============================================================================
module tb_control_unit;
   import ctrl_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic [15:0] IM_data;
   logic [6:0]  IM_Addr;
   logic [15:0] IR;
   logic [7:0]  D_Addr;
   logic        D_wr, RF_s, RF_W_en;
   logic [3:0]  RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, State;
   logic [2:0]  ALU_s0;

   logic [15:0] im [128];
   assign IM_data = im[IM_Addr];

   control_unit #(.PC_W(7), .D_ADDR_W(8)) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .IM_data    (IM_data),
      .IM_Addr    (IM_Addr),
      .IR         (IR),
      .D_Addr     (D_Addr),
      .D_wr       (D_wr),
      .RF_s       (RF_s),
      .RF_W_en    (RF_W_en),
      .RF_W_Addr  (RF_W_Addr),
      .RF_Ra_Addr (RF_Ra_Addr),
      .RF_Rb_Addr (RF_Rb_Addr),
      .ALU_s0     (ALU_s0),
      .State      (State)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [3:0]  st;
      logic [6:0]  pc;
      logic [15:0] ir;
      logic [7:0]  d_addr;
      logic        d_wr;
      logic        rf_s;
      logic        w_en;
      logic [3:0]  w_addr;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [2:0]  alu;
   } rec_t;

   rec_t       exp_q[$];
   logic [6:0] m_pc;
   logic [15:0] m_ir;
   bit         m_halted;

   function automatic rec_t blank(input logic [3:0] st);
      rec_t r;
      r.st = st; r.pc = m_pc; r.ir = m_ir;
      r.d_addr = 8'h00; r.d_wr = 1'b0; r.rf_s = 1'b0; r.w_en = 1'b0;
      r.w_addr = 4'h0; r.ra = 4'h0; r.rb = 4'h0; r.alu = 3'd0;
      return r;
   endfunction

   // Push the complete expected cycle stream for the next instruction
   task automatic expand();
      rec_t        r;
      logic [15:0] ins;
      logic [3:0]  op;
      if (m_halted) begin
         exp_q.push_back(blank(ST_HALT));
         return;
      end
      ins = im[m_pc];
      op  = ins[15:12];
      exp_q.push_back(blank(ST_FETCH));
      m_pc = m_pc + 7'd1;
      m_ir = ins;
      r = blank(ST_DECODE);
      if (op == 4'd1) begin
         r.ra = ins[11:8]; r.d_addr = ins[7:0];
      end else if (op == 4'd2) begin
         r.d_addr = ins[11:4]; r.w_addr = ins[3:0];
      end else if (op == 4'd3 || op == 4'd4) begin
         r.ra = ins[11:8]; r.rb = ins[7:4]; r.w_addr = ins[3:0];
      end
      exp_q.push_back(r);
      case (op)
         4'd1: begin
            r = blank(ST_STORE);
            r.ra = ins[11:8]; r.d_addr = ins[7:0]; r.d_wr = 1'b1;
            exp_q.push_back(r);
         end
         4'd2: begin
            r = blank(ST_LOAD_A);
            r.d_addr = ins[11:4]; r.rf_s = 1'b1;
            exp_q.push_back(r);
            r = blank(ST_LOAD_B);
            r.d_addr = ins[11:4]; r.rf_s = 1'b1; r.w_en = 1'b1; r.w_addr = ins[3:0];
            exp_q.push_back(r);
         end
         4'd3, 4'd4: begin
            r = blank(op == 4'd3 ? ST_ADD : ST_SUB);
            r.ra = ins[11:8]; r.rb = ins[7:4]; r.w_addr = ins[3:0];
            r.w_en = 1'b1; r.alu = (op == 4'd3) ? 3'd1 : 3'd2;
            exp_q.push_back(r);
         end
         4'd5: begin
            m_halted = 1'b1;
            exp_q.push_back(blank(ST_HALT));
         end
         default: exp_q.push_back(blank(ST_NOOP));
      endcase
   endtask

   task automatic compare(input rec_t r);
      check("state",   16'(State),      16'(r.st));
      check("im_addr", 16'(IM_Addr),    16'(r.pc));
      check("ir",      IR,              r.ir);
      check("d_addr",  16'(D_Addr),     16'(r.d_addr));
      check("d_wr",    16'(D_wr),       16'(r.d_wr));
      check("rf_s",    16'(RF_s),       16'(r.rf_s));
      check("rf_w_en", 16'(RF_W_en),    16'(r.w_en));
      check("w_addr",  16'(RF_W_Addr),  16'(r.w_addr));
      check("ra",      16'(RF_Ra_Addr), 16'(r.ra));
      check("rb",      16'(RF_Rb_Addr), 16'(r.rb));
      check("alu",     16'(ALU_s0),     16'(r.alu));
      check("strobe_excl", 16'(D_wr & RF_W_en), 16'h0);
   endtask

   // Hold reset for two cycles, check the reset image, release on a low clock
   task automatic do_reset();
      Reset_n = 1'b0;
      m_pc = 7'd0; m_ir = 16'h0000; m_halted = 1'b0;
      exp_q.delete();
      @(negedge Clk);
      @(negedge Clk);
      compare(blank(ST_INIT));
      Reset_n = 1'b1;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk);
         @(negedge Clk);
         if (exp_q.size() == 0) expand();
         compare(exp_q.pop_front());
      end
   endtask

   task automatic fill_noop();
      for (int i = 0; i < 128; i++) im[i] = 16'h0000;
   endtask

   function automatic logic [15:0] rand_instr(input bit allow_halt);
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (!allow_halt && op == 4'd5) op = 4'd3;
      return {op, 12'($urandom_range(0, 4095))};
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      fill_noop();

      // NOOP stream
      do_reset();
      run_cycles(12);

      // ADD
      fill_noop(); im[0] = 16'h3125;
      do_reset();
      run_cycles(9);

      // LOAD
      fill_noop(); im[0] = 16'h21B3;
      do_reset();
      run_cycles(10);

      // STORE then SUB
      fill_noop(); im[0] = 16'h14A7; im[1] = 16'h4312;
      do_reset();
      run_cycles(10);

      // HALT is terminal; the illegal word after it is never fetched
      fill_noop(); im[0] = 16'h5000; im[1] = 16'h9FFF;
      do_reset();
      run_cycles(25);

      // Illegal opcode behaves as NOOP
      fill_noop(); im[0] = 16'h9FFF;
      do_reset();
      run_cycles(6);

      // Asynchronous reset while in LOAD_B
      fill_noop(); im[0] = 16'h21B3;
      do_reset();
      run_cycles(4);
      check("in_load_b", 16'(State), 16'(ST_LOAD_B));
      #2 Reset_n = 1'b0;
      #1;
      check("async_rst_wen",   16'(RF_W_en), 16'h0);
      check("async_rst_state", 16'(State),   16'(ST_INIT));
      check("async_rst_pc",    16'(IM_Addr), 16'h0);
      do_reset();
      run_cycles(8);

      // PC wrap through a NOOP stream: DECODE of instruction 127 shows PC 0
      fill_noop();
      do_reset();
      run_cycles(383);
      check("pc_wrap", 16'(IM_Addr), 16'h0);
      run_cycles(6);

      // Random program without HALT, long enough to wrap the PC
      for (int i = 0; i < 128; i++) im[i] = rand_instr(1'b0);
      do_reset();
      run_cycles(600);

      // Random program ending in a HALT
      for (int i = 0; i < 128; i++) im[i] = rand_instr(1'b0);
      im[$urandom_range(10, 40)] = 16'h5000 | 16'($urandom_range(0, 4095));
      do_reset();
      run_cycles(300);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
